// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin sequencer for the shared fetch/data memory port
module mem_arbiter #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy,
    output logic            last_grant
);

    localparam int BW = DW / 8;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state, state_nx;
    logic [3:0]      cnt;
    logic            owner;
    logic [AW-1:0]   a_addr;
    logic            a_we;
    logic [BW-1:0]   a_be;
    logic [DW-1:0]   a_wdata;
    logic            grant;
    logic            grant_d;

    // Outputs decode only from state and the latched owner, so req never reaches mem_*.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        grant_d  = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        i_ack    = 1'b0;
        d_ack    = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant    = 1'b1;
                    grant_d  = (i_req && d_req) ? ~last_grant : d_req;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = a_we;
                busy   = 1'b1;
                if (cnt == 4'd0) state_nx = DONE;
            end
            DONE: begin
                busy  = 1'b1;
                i_ack = ~owner;
                d_ack = owner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_addr  = a_addr;
    assign mem_be    = a_be;
    assign mem_wdata = a_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b0;
            owner      <= 1'b0;
            a_addr     <= '0;
            a_we       <= 1'b0;
            a_be       <= '0;
            a_wdata    <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner      <= grant_d;
                last_grant <= grant_d;
                cnt        <= WAIT_CNT;
                if (grant_d) begin
                    a_addr  <= d_addr;
                    a_we    <= d_we;
                    a_be    <= d_be;
                    a_wdata <= d_wdata;
                end else begin
                    a_addr  <= i_addr;
                    a_we    <= 1'b0;
                    a_be    <= '1;
                    a_wdata <= '0;
                end
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // mem_rdata is valid during DONE, one cycle after the last sampled mem_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (state == DONE && !a_we) begin
            if (owner) d_rdata <= mem_rdata;
            else       i_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    localparam int W  = 2;
    localparam int P  = W + 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_req, i_ack, d_req, d_we, d_ack;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, mem_be;
    logic        mem_en, mem_we, busy, last_grant;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        z_i_req, z_i_ack, z_d_ack, z_mem_en, z_mem_we, z_busy, z_last_grant;
    logic [31:0] z_i_addr, z_i_rdata, z_d_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;
    logic [3:0]  z_mem_be;

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT(W)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .last_grant(last_grant)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_req(z_i_req), .i_addr(z_i_addr), .i_rdata(z_i_rdata), .i_ack(z_i_ack),
        .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(z_d_rdata), .d_ack(z_d_ack),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_be(z_mem_be), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata),
        .busy(z_busy), .last_grant(z_last_grant)
    );

    function automatic logic [31:0] init_word(int k);
        return 32'h00A00093 + 32'(k) * 32'h01010101;
    endfunction

    // Synchronous memory devices: read data appears the cycle after mem_en is sampled.
    logic [31:0] mem_arr [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) mem_arr[k] <= init_word(k);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem_arr[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= mem_arr[mem_addr[5:2]];
        end
    end

    always @(posedge clk) begin
        if (rst)           z_mem_rdata <= '0;
        else if (z_mem_en) z_mem_rdata <= 32'h0A0B0C0D ^ z_mem_addr;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: memory image, expected rdata, round-robin owner.
    logic [31:0] ref_mem [16];
    logic [31:0] exp_irdata, exp_drdata;
    bit          m_last;
    bit          cur_o;
    logic [31:0] cur_a, cur_wd;
    bit          cur_we;
    logic [3:0]  cur_be;

    task automatic model_reset();
        for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);
        exp_irdata = '0;
        exp_drdata = '0;
        m_last     = 1'b0;
    endtask

    task automatic pick();
        cur_o  = (i_req && d_req) ? ~m_last : d_req;
        m_last = cur_o;
        if (cur_o) begin
            cur_a = d_addr; cur_we = d_we; cur_be = d_be; cur_wd = d_wdata;
        end else begin
            cur_a = i_addr; cur_we = 1'b0; cur_be = 4'hF; cur_wd = '0;
        end
    endtask

    task automatic retire();
        if (cur_we) begin
            for (int b = 0; b < 4; b++)
                if (cur_be[b]) ref_mem[cur_a[5:2]][8*b +: 8] = cur_wd[8*b +: 8];
        end else if (cur_o) begin
            exp_drdata = ref_mem[cur_a[5:2]];
        end else begin
            exp_irdata = ref_mem[cur_a[5:2]];
        end
    endtask

    // Runs n grants cycle-exactly; called right after a negedge with requests driven.
    task automatic run(input bit drop, input bit scramble, input int n);
        int j, rel;
        pick();
        for (int c = 1; c <= n * P; c++) begin
            @(negedge clk);
            j   = (c - 1) / P;
            rel = c - j * P;
            if (rel <= W + 1) begin
                chk("acc_mem_en", 64'(mem_en), 64'(1));
                chk("acc_mem_addr", 64'(mem_addr), 64'(cur_a));
                chk("acc_mem_we", 64'(mem_we), 64'(cur_we));
                chk("acc_mem_be", 64'(mem_be), 64'(cur_be));
                if (cur_we) chk("acc_mem_wdata", 64'(mem_wdata), 64'(cur_wd));
                chk("acc_busy", 64'(busy), 64'(1));
                chk("acc_last_grant", 64'(last_grant), 64'(cur_o));
                chk("acc_i_ack", 64'(i_ack), 64'(0));
                chk("acc_d_ack", 64'(d_ack), 64'(0));
                if (scramble) begin
                    i_addr  = $urandom;
                    d_addr  = $urandom;
                    d_we    = 1'($urandom);
                    d_be    = 4'($urandom);
                    d_wdata = $urandom;
                end
            end else if (rel == W + 2) begin
                chk("done_mem_en", 64'(mem_en), 64'(0));
                chk("done_i_ack", 64'(i_ack), 64'(cur_o == 1'b0));
                chk("done_d_ack", 64'(d_ack), 64'(cur_o == 1'b1));
                chk("done_busy", 64'(busy), 64'(1));
                retire();
                if (drop) begin
                    if (cur_o) d_req = 1'b0;
                    else       i_req = 1'b0;
                end
            end else begin
                chk("idle_busy", 64'(busy), 64'(0));
                chk("idle_mem_en", 64'(mem_en), 64'(0));
                chk("idle_i_ack", 64'(i_ack), 64'(0));
                chk("idle_d_ack", 64'(d_ack), 64'(0));
                chk("idle_i_rdata", 64'(i_rdata), 64'(exp_irdata));
                chk("idle_d_rdata", 64'(d_rdata), 64'(exp_drdata));
                if (c == n * P) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                end else begin
                    pick();
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; z_i_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit ri, rd, dr;
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        z_i_req = 1'b0; z_i_addr = '0;
        do_reset();

        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_be", 64'(mem_be), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_acks", 64'({i_ack, d_ack}), 64'(0));
        chk("rst_i_rdata", 64'(i_rdata), 64'(0));
        chk("rst_d_rdata", 64'(d_rdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_last_grant", 64'(last_grant), 64'(0));

        i_addr = 32'h100; i_req = 1'b1;
        run(1'b1, 1'b0, 1);
        chk("fetch_0x100_data", 64'(i_rdata), 64'(32'h00A00093));

        d_addr = 32'h2004; d_be = 4'h3; d_wdata = 32'hDEADBEEF; d_we = 1'b1; d_req = 1'b1;
        run(1'b1, 1'b0, 1);

        do_reset();
        i_addr = 32'h8; d_addr = 32'hC; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
        run(1'b0, 1'b0, 4);

        d_addr = 32'h30; d_we = 1'b0; d_req = 1'b1;
        run(1'b1, 1'b0, 1);
        i_addr = 32'h14; i_req = 1'b1;
        run(1'b1, 1'b1, 1);

        i_addr = 32'h24; i_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_en", 64'(mem_en), 64'(0));
        chk("arst_acks", 64'({i_ack, d_ack}), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_i_rdata", 64'(i_rdata), 64'(0));
        i_req = 1'b0;
        @(negedge clk);
        chk("arst_hold_ack", 64'({i_ack, d_ack}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("arst_after_ack", 64'({i_ack, d_ack}), 64'(0));
        i_addr = 32'h28; i_req = 1'b1;
        run(1'b1, 1'b0, 1);

        z_i_addr = 32'h44; z_i_req = 1'b1;
        @(negedge clk);
        chk("w0_mem_en_c1", 64'(z_mem_en), 64'(1));
        chk("w0_mem_addr", 64'(z_mem_addr), 64'(32'h44));
        chk("w0_ack_c1", 64'(z_i_ack), 64'(0));
        @(negedge clk);
        chk("w0_mem_en_c2", 64'(z_mem_en), 64'(0));
        chk("w0_ack_c2", 64'(z_i_ack), 64'(1));
        z_i_req = 1'b0;
        @(negedge clk);
        chk("w0_ack_c3", 64'(z_i_ack), 64'(0));
        chk("w0_busy_c3", 64'(z_busy), 64'(0));
        chk("w0_i_rdata", 64'(z_i_rdata), 64'(32'h0A0B0C0D ^ 32'h44));

        for (int it = 0; it < 25; it++) begin
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_we    = 1'($urandom);
            d_be    = 4'($urandom);
            d_wdata = $urandom;
            ri = 1'($urandom);
            rd = 1'($urandom);
            if (!ri && !rd) rd = 1'b1;
            dr = (it % 4) != 3;
            i_req = ri;
            d_req = rd;
            run(dr, 1'($urandom), dr ? (int'(ri) + int'(rd)) : 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single shared memory port of the RVS9 multicycle core. It serves two requesters: the instruction-fetch path, driven during the fetch micro-states, and the load/store data path, driven during the lw/sw micro-states. One access runs at a time. Each access lasts a fixed number of wait states. Completion is signalled by a one-cycle ack that the control unit uses to advance its micro-PC.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 bits)
- WAIT, 2, wait states per access (0..15); mem_en is held for WAIT+1 cycles

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction fetch request; held until i_ack
- i_addr  in  AW  fetch address
- i_rdata  out  DW  registered fetch data
- i_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  store byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  registered load data
- d_ack  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; synchronous, valid the cycle after mem_en is sampled
- busy  out  1  high in ACCESS and DONE
- last_grant  out  1  0 = fetch, 1 = data; owner of the most recent grant

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- **IDLE**
  - If neither request is high: stay in IDLE.
  - If only one request is high: grant it.
  - If both are high: grant the port that is not last_grant (round-robin).
  - On grant: latch owner, address, we, be and wdata into the access registers; load cnt = WAIT; update last_grant; go to ACCESS.
- **ACCESS**
  - mem_en = 1. mem_addr, mem_we, mem_be and mem_wdata are driven from the latched registers.
  - Fetch grants drive mem_we = 0 and mem_be = all ones.
  - cnt decrements each cycle. When cnt == 0, go to DONE.
- **DONE**
  - mem_en = 0.
  - For a read, capture mem_rdata into the owner's rdata register. For a write, the owner's rdata register is unchanged.
  - Pulse the owner's ack. Go to IDLE.
- Requests are not sampled in ACCESS or DONE.
- A request still high in the IDLE cycle after its ack is treated as a new request.
- Requester inputs may change during ACCESS without effect, because all access fields are latched at grant.
- Requester drops req mid-access: the access completes and ack still pulses.
- i_rdata and d_rdata hold their value until the next read completion on the same port.

## Timing
- Reset values:
  - state = IDLE, cnt = 0, last_grant = 0
  - mem_en, mem_we, i_ack, d_ack = 0
  - mem_be, mem_addr, mem_wdata = 0
  - i_rdata, d_rdata = 0
  - busy = 0
- Latency: request high in IDLE at cycle 0 → ACCESS in cycles 1..WAIT+1 → ack in cycle WAIT+2. Total is WAIT+3 cycles per access, including the IDLE return.
- Back-to-back with both requests held: grants alternate, one grant every WAIT+3 cycles. The first tie after reset goes to data, because last_grant resets to 0.
- WAIT = 0: ACCESS lasts exactly one cycle.
- Asynchronous reset in any state:
  - FSM returns to IDLE and clears mem_en and both acks immediately.
  - The in-flight access is abandoned, with no ack.
  - rdata registers clear.
- All outputs are registered, or decoded only from the state and latched registers. There is no combinational path from req to mem_*.

## Test plan
- Reset, then i_req = 1 with i_addr = 0x100 and WAIT = 2 → mem_en high for 3 cycles with mem_addr = 0x100, mem_we = 0, mem_be = 0xF; i_ack at cycle 4; i_rdata = mem_rdata (e.g. 0x00A00093).
- d_req with d_we = 1, d_addr = 0x2004, d_be = 0x3, d_wdata = 0xDEADBEEF → mem_we = 1 and mem_be = 0x3 for 3 cycles; d_ack at cycle 4; d_rdata unchanged.
- i_req and d_req both held from reset → grant order D, I, D, I; acks 5 cycles apart; last_grant toggles.
- Load completes, then d_addr changes during a following fetch access → mem_addr stays at the latched fetch address; d_rdata holds the previous load value.
- rst asserted in the second ACCESS cycle → mem_en drops without waiting for a clock edge; no ack; next request starts a fresh 3-cycle access.
- WAIT = 0 build, single fetch → mem_en high for 1 cycle; i_ack at cycle 2.
